pc_fetch_seq: RTL and testbench
===============================

Name: pc_fetch_seq

Overview:
- Program-counter sequencer for the RV32I single-issue core; the sequential consumer of the plus4 next-PC adder.
- Holds the architectural fetch PC and issues instruction-memory requests over a valid/ready handshake.
- Advances by 4 per accepted request; accepts branch/jump redirects from execute.
- Traps on a misaligned redirect target.

Parameters:
- XLEN, 32, datapath/address width; only 32 supported.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC; suppresses advance but not redirect.
- redir_valid  in  1  redirect request, single-cycle pulse.
- redir_target  in  XLEN  redirect destination address.
- trap_clr  in  1  leave TRAP state and resume at RESET_VEC.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  instruction memory accepts request.
- imem_addr  out  XLEN  fetch address (= pc).
- misalign  out  1  sticky trap flag.
- trap_addr  out  XLEN  offending redirect target.

Behaviour:
- Reset (async assert, sync-free deassert):
  - pc=RESET_VEC, state=BOOT.
  - imem_req_valid=0, misalign=0, trap_addr=0.
- States and transitions:
  - BOOT: one idle cycle, imem_req_valid=0; next state RUN.
  - RUN: imem_req_valid=!stall; imem_addr=pc.
  - TRAP: imem_req_valid=0, misalign=1, pc frozen.
- Advance: in RUN, when imem_req_valid && imem_req_ready && !redir_valid, pc<=pc+4 next cycle.
- Arithmetic: pc+4 is mod 2^32; 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- Redirect (priority over advance and stall, in BOOT or RUN):
  - Aligned target (redir_target[1:0]==0): pc<=redir_target, state<=RUN.
  - Misaligned target: state<=TRAP, trap_addr<=redir_target, pc unchanged.
- Same-cycle handshake and redirect: a request accepted in the same cycle as redir_valid counts as accepted; its address is the old pc, and the next pc is the redirect target.
- Stall: while stall=1 and no redirect, pc holds and imem_req_valid=0. A valid request, once raised, holds its address until accepted.
- Latency: redirect to first request at the new address is exactly 1 cycle.
- TRAP exit:
  - trap_clr=1 in TRAP: pc<=RESET_VEC, misalign<=0, state<=BOOT.
  - trap_clr is ignored outside TRAP.
  - redir_valid is ignored in TRAP.
- Reset mid-operation: immediate return to reset values; a pending handshake is dropped.

Optional Feature:
- Macro: PC_FETCH_CNT_EN.
- Defined: adds output fetch_cnt (32 bits).
  - Reset 0; increments on every accepted request (valid && ready).
  - Wraps at 2^32; cleared by trap_clr.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package pc_fetch_pkg:
  - state enum {BOOT, RUN, TRAP}.
  - INSN_BYTES=4, XLEN.
  - Alignment-check function (addr[1:0]==0).
- Sub-module: instantiate the existing plus4 adder for the pc+4 term; no other sub-module.

Test Plan:
- Reset release, imem_req_ready=1 constantly: cycle 0 valid=0, then imem_addr 0x0, 0x4, 0x8, 0xC on successive cycles.
- ready=0 for 3 cycles at pc=0x8: imem_addr stays 0x8, valid stays 1; advances to 0xC the cycle after ready=1.
- redir_valid with target 0x100 while stall=1 at pc=0x10: next cycle imem_addr=0x100; pc holds 0x100 until stall drops, then 0x104.
- redir target 0x202: misalign=1, trap_addr=0x202, valid=0.
  - Later redirects to 0x300 are ignored.
  - trap_clr: next cycle BOOT, then imem_addr=RESET_VEC.
- Redirect to 0xFFFF_FFFC, ready=1: imem_addr 0xFFFF_FFFC then 0x0000_0000, no misalign.
- rst_n low mid-run at pc=0x40: outputs reset asynchronously (valid=0 before next edge); after release the sequence restarts at RESET_VEC. With PC_FETCH_CNT_EN, fetch_cnt=0 after reset and equals the accepted-request count.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared types and helpers for the fetch-PC sequencer.
package pc_fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INSN_BYTES = 4;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StTrap
  } state_e;

  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_seq_plus4.sv
// Next-sequential-PC adder: pc + one instruction, wrapping mod 2^XLEN.
module pc_fetch_seq_plus4
  import pc_fetch_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  output logic [XLEN-1:0] sum_o
);

  assign sum_o = a_i + XLEN'(INSN_BYTES);

endmodule

// File: rtl/pc_fetch_seq.sv
// RV32I fetch-PC sequencer: BOOT/RUN/TRAP, valid/ready fetch requests, redirects.
// Optional fetch_cnt output when PC_FETCH_CNT_EN is defined.
module pc_fetch_seq #(
  parameter int unsigned    XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_target,
  input  logic            trap_clr,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  output logic            misalign,
  output logic [XLEN-1:0] trap_addr
`ifdef PC_FETCH_CNT_EN
  ,
  output logic [31:0]     fetch_cnt
`endif
);

  import pc_fetch_pkg::*;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] trap_addr_q, trap_addr_d;
  logic [XLEN-1:0] pc_plus4;
  logic            accept;

  // Adder is fixed at the package width; only XLEN == 32 is supported.
  pc_fetch_seq_plus4 u_plus4 (
    .a_i   (pc_q),
    .sum_o (pc_plus4)
  );

  assign imem_req_valid = (state_q == StRun) && !stall;
  assign accept         = imem_req_valid && imem_req_ready;
  assign imem_addr      = pc_q;
  assign misalign       = (state_q == StTrap);
  assign trap_addr      = trap_addr_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    trap_addr_d = trap_addr_q;
    unique case (state_q)
      StBoot, StRun: begin
        // Redirect wins over advance and stall; the old-pc handshake still counts.
        if (redir_valid) begin
          if (is_aligned(redir_target)) begin
            pc_d    = redir_target;
            state_d = StRun;
          end else begin
            trap_addr_d = redir_target;
            state_d     = StTrap;
          end
        end else if (state_q == StBoot) begin
          state_d = StRun;
        end else if (accept) begin
          pc_d = pc_plus4;
        end
      end
      StTrap: begin
        if (trap_clr) begin
          pc_d    = RESET_VEC;
          state_d = StBoot;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StBoot;
      pc_q        <= RESET_VEC;
      trap_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      trap_addr_q <= trap_addr_d;
    end
  end

`ifdef PC_FETCH_CNT_EN
  logic [31:0] fetch_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
    end else if ((state_q == StTrap) && trap_clr) begin
      fetch_cnt_q <= '0;
    end else if (accept) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq with hand-computed expectations.
module tb_pc_fetch_seq;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        trap_clr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        misalign;
  logic [31:0] trap_addr;
`ifdef PC_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  int vectors;
  int miscompares;

  pc_fetch_seq #(
    .XLEN      (32),
    .RESET_VEC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redir_valid    (redir_valid),
    .redir_target   (redir_target),
    .trap_clr       (trap_clr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .misalign       (misalign),
    .trap_addr      (trap_addr)
`ifdef PC_FETCH_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled away from the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst_n          = 1'b0;
    stall          = 1'b0;
    redir_valid    = 1'b0;
    redir_target   = 32'h0;
    trap_clr       = 1'b0;
    imem_req_ready = 1'b1;
    #2;
    chk("rst_valid", imem_req_valid, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_misalign", misalign, 0);
    chk("rst_trap_addr", trap_addr, 32'h0);

    // Release reset: one BOOT cycle, then sequential fetch.
    cyc(); cyc();
    rst_n = 1'b1; #1;
    chk("boot_valid", imem_req_valid, 0);
    cyc(); chk("seq0_valid", imem_req_valid, 1); chk("seq0_addr", imem_addr, 32'h0);
`ifdef PC_FETCH_CNT_EN
    chk("cnt_after_reset", fetch_cnt, 32'd0);
`endif
    cyc(); chk("seq4_addr", imem_addr, 32'h4);
`ifdef PC_FETCH_CNT_EN
    chk("cnt_one", fetch_cnt, 32'd1);
`endif
    cyc(); chk("seq8_addr", imem_addr, 32'h8);

    // Back-pressure: three cycles with ready low hold the request.
    imem_req_ready = 1'b0; #1;
    chk("bp0_addr", imem_addr, 32'h8); chk("bp0_valid", imem_req_valid, 1);
    cyc(); chk("bp1_addr", imem_addr, 32'h8); chk("bp1_valid", imem_req_valid, 1);
    cyc(); chk("bp2_addr", imem_addr, 32'h8);
    cyc(); imem_req_ready = 1'b1; #1;
    chk("bp3_addr", imem_addr, 32'h8); chk("bp3_valid", imem_req_valid, 1);
    cyc(); chk("seqc_addr", imem_addr, 32'hC);
    cyc(); chk("seq10_addr", imem_addr, 32'h10);

    // Redirect under stall takes effect; pc then holds until stall drops.
    stall = 1'b1; redir_valid = 1'b1; redir_target = 32'h100; #1;
    chk("stall_valid", imem_req_valid, 0);
    cyc(); redir_valid = 1'b0; #1;
    chk("redir_addr", imem_addr, 32'h100); chk("redir_stall_valid", imem_req_valid, 0);
    cyc(); chk("stall_hold_addr", imem_addr, 32'h100);
    stall = 1'b0; #1;
    chk("unstall_valid", imem_req_valid, 1); chk("unstall_addr", imem_addr, 32'h100);
    cyc(); chk("adv104_addr", imem_addr, 32'h104);

    // Misaligned redirect, accepted handshake in the same cycle.
    redir_valid = 1'b1; redir_target = 32'h202; #1;
    cyc(); redir_valid = 1'b0; #1;
    chk("trap_misalign", misalign, 1);
    chk("trap_addr", trap_addr, 32'h202);
    chk("trap_valid", imem_req_valid, 0);
    chk("trap_pc_frozen", imem_addr, 32'h104);
    redir_valid = 1'b1; redir_target = 32'h300; #1;
    cyc(); redir_valid = 1'b0; #1;
    chk("trap_ign_redir_addr", imem_addr, 32'h104);
    chk("trap_ign_redir_mis", misalign, 1);
    chk("trap_ign_redir_taddr", trap_addr, 32'h202);
    trap_clr = 1'b1; #1;
    cyc(); trap_clr = 1'b0; #1;
    chk("clr_boot_valid", imem_req_valid, 0);
    chk("clr_misalign", misalign, 0);
    chk("clr_addr", imem_addr, 32'h0);
`ifdef PC_FETCH_CNT_EN
    chk("cnt_cleared", fetch_cnt, 32'd0);
`endif
    cyc(); chk("clr_run_valid", imem_req_valid, 1); chk("clr_run_addr", imem_addr, 32'h0);

    // trap_clr outside TRAP has no effect.
    trap_clr = 1'b1; #1;
    cyc(); trap_clr = 1'b0; #1;
    chk("clr_ignored_addr", imem_addr, 32'h4);

    // Aligned redirect to top of address space, then wrap to zero.
    redir_valid = 1'b1; redir_target = 32'hFFFF_FFFC; #1;
    cyc(); redir_valid = 1'b0; #1;
    chk("top_addr", imem_addr, 32'hFFFF_FFFC); chk("top_valid", imem_req_valid, 1);
    cyc(); chk("wrap_addr", imem_addr, 32'h0); chk("wrap_misalign", misalign, 0);

    // Run to 0x40, then assert reset mid-cycle.
    repeat (16) cyc();
    chk("run40_addr", imem_addr, 32'h40);
    #2; rst_n = 1'b0; #1;
    chk("async_valid", imem_req_valid, 0);
    chk("async_addr", imem_addr, 32'h0);
    cyc();
    rst_n = 1'b1; #1;
    chk("rerst_boot_valid", imem_req_valid, 0);
    cyc(); chk("rerst_addr0", imem_addr, 32'h0);
`ifdef PC_FETCH_CNT_EN
    chk("cnt_rerst", fetch_cnt, 32'd0);
`endif
    cyc(); chk("rerst_addr4", imem_addr, 32'h4);
`ifdef PC_FETCH_CNT_EN
    chk("cnt_rerst_one", fetch_cnt, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
